// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. The remainder drives HI and the quotient drives LO.
// ready_o pulses for one cycle when hi_o/lo_o are valid; busy_o stalls EX while the divider iterates.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             busy_q, busy_d, ready_q, ready_d;

  logic             a_neg, b_neg, ge;
  logic [WIDTH-1:0] a_abs, b_abs, step_rem, step_quo;
  logic [WIDTH:0]   shifted;

  always_comb begin
    a_neg    = signed_i & dividend_i[WIDTH-1];
    b_neg    = signed_i & divisor_i[WIDTH-1];
    a_abs    = a_neg ? -dividend_i : dividend_i;
    b_abs    = b_neg ? -divisor_i : divisor_i;
    // Compare at WIDTH+1 bits; when the trial succeeds the difference fits in WIDTH bits.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    step_rem = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ge};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          cnt_d   = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          if (divisor_i == '0) begin
            lo_d    = '1;
            hi_d    = dividend_i;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            lo_d    = q_neg_q ? -step_quo : step_quo;
            hi_d    = r_neg_q ? -step_rem : step_rem;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: accepted divides push {hi,lo} from an arithmetic reference model,
// and a monitor pops and compares on every ready_o pulse.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
  logic [31:0] dividend_i = '0, divisor_i = '0;
  logic        busy_o, ready_o;
  logic [31:0] hi_o, lo_o;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [63:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain integer division (truncates toward zero).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 expected=0 hi=%h lo=%h", hi_o, lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", hi_o, mon_e[63:32]);
        check("lo", lo_o, mon_e[31:0]);
      end
    end
  end

  task automatic wait_ready(output int lat, output int bc);
    lat = 0;
    bc  = int'(busy_o);
    while (!ready_o && lat < 60) begin
      @(negedge clk);
      lat++;
      bc += int'(busy_o);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat, bc;
    @(negedge clk);
    dividend_i = a; divisor_i = b; signed_i = s; start_i = 1'b1;
    last_res = model(a, b, s);
    exp_q.push_back(last_res);
    @(negedge clk);
    start_i = 1'b0;
    dividend_i = $urandom; divisor_i = $urandom; signed_i = 1'($urandom);
    wait_ready(lat, bc);
    check("latency", 32'(lat), (b == 0) ? 32'd1 : 32'd33);
    check("busy_cycles", 32'(bc), (b == 0) ? 32'd0 : 32'd32);
  endtask

  task automatic start_raw(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend_i = a; divisor_i = b; signed_i = s; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    int lat, bc, seen;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd5, 32'd0, 1'b1);

    // Annul during BUSY: no pulse, outputs keep the previous result.
    start_raw(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); seen += int'(ready_o); end
    check("annul_no_ready", 32'(seen), 32'd0);
    check("annul_hold_hi", hi_o, last_res[63:32]);
    check("annul_hold_lo", lo_o, last_res[31:0]);
    run_op(32'd9, 32'd3, 1'b0);

    // start_i held through DONE launches a second divide from IDLE.
    @(negedge clk);
    dividend_i = 32'd50; divisor_i = 32'd6; signed_i = 1'b0; start_i = 1'b1;
    exp_q.push_back(model(32'd50, 32'd6, 1'b0));
    @(negedge clk);
    wait_ready(lat, bc);
    check("b2b_first_latency", 32'(lat), 32'd33);
    dividend_i = 32'hFFFF_FF00; divisor_i = 32'd16; signed_i = 1'b1;
    last_res = model(32'hFFFF_FF00, 32'd16, 1'b1);
    exp_q.push_back(last_res);
    @(negedge clk);
    start_i = 1'b0;
    wait_ready(lat, bc);
    check("b2b_second_latency", 32'(lat), 32'd33);

    // start_i together with annul_i in IDLE is ignored.
    @(negedge clk);
    dividend_i = 32'd77; divisor_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("idle_annul_busy", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (4) begin @(negedge clk); seen += int'(ready_o); end
    check("idle_annul_no_ready", 32'(seen), 32'd0);

    // Reset mid-operation clears everything on the next edge.
    start_raw(32'd100, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(3))
        0: rb = 32'($urandom_range(15));
        1: rb = $urandom;
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(7));
        default: rb = $urandom >> $urandom_range(31);
      endcase
      if (i % 10 == 9) ra = 32'h8000_0000;
      run_op(ra, rb, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
